mac_activation_collector: RTL

//  Downstream stage of the pipelined multiply-accumulate unit. Restarts the MAC (drives its rst) per window,

---
 rtl/mac_activation_collector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mac_activation_collector.sv
// Post-MAC stage: restarts the MAC once per window, adds bias to its result, rounds,
// applies ReLU with saturation and queues the activation in a show-ahead output FIFO.
module mac_activation_collector #(
    parameter int PIXEL_WIDTH = 10,
    parameter int ACC_WIDTH   = 26,
    parameter int FRAC_BITS   = 18,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [ACC_WIDTH-1:0]       mac_out,
    input  logic                       mac_done,
    input  logic [ACC_WIDTH-1:0]       bias,
    output logic                       mac_rst,
    output logic [PIXEL_WIDTH-1:0]     out_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam int RND_W = ACC_WIDTH + 2;
    localparam logic signed [RND_W-1:0] PIX_MAX = RND_W'((1 << (PIXEL_WIDTH - 1)) - 1);
    localparam logic [RND_W-1:0] HALF_LSB = RND_W'(1) << (FRAC_BITS - 1);

    // state   | meaning
    // IDLE    | MAC held in reset, waiting for enable
    // RUN     | MAC accumulating, waiting for mac_done
    // RESTART | one-cycle MAC reset after a capture
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESTART
    } state_t;

    state_t                 state;
    logic                   cap_valid;
    logic [ACC_WIDTH-1:0]   cap_mac;
    logic [ACC_WIDTH-1:0]   cap_bias;
    logic                   sum_valid;
    logic [SUM_W-1:0]       sum_q;
    logic signed [RND_W-1:0] rnd_sum;
    logic signed [RND_W-1:0] rnd;
    logic [PIXEL_WIDTH-1:0] act;

    logic [PIXEL_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       rd_next;
    logic                   push;
    logic                   pop;
    logic                   push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mac_rst   <= 1'b1;
            cap_valid <= 1'b0;
            cap_mac   <= '0;
            cap_bias  <= '0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RUN;
                        mac_rst <= 1'b0;
                    end
                end
                RUN: begin
                    if (mac_done) begin
                        cap_valid <= 1'b1;
                        cap_mac   <= mac_out;
                        cap_bias  <= bias;
                        state     <= RESTART;
                        mac_rst   <= 1'b1;
                    end else if (!enable) begin
                        state   <= IDLE;
                        mac_rst <= 1'b1;
                    end
                end
                RESTART: begin
                    // mac_done is still high from the finished window, so it is not looked at here
                    if (enable) begin
                        state   <= RUN;
                        mac_rst <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        mac_rst <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mac_rst <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_valid <= 1'b0;
            sum_q     <= '0;
        end else begin
            sum_valid <= cap_valid;
            if (cap_valid) begin
                sum_q <= {cap_mac[ACC_WIDTH-1], cap_mac} + {cap_bias[ACC_WIDTH-1], cap_bias};
            end
        end
    end

    // Round half up, then ReLU and clamp to the largest positive pixel value.
    always_comb begin
        rnd_sum = {sum_q[SUM_W-1], sum_q} + HALF_LSB;
        rnd     = rnd_sum >>> FRAC_BITS;
        if (rnd[RND_W-1]) begin
            act = '0;
        end else if (rnd > PIX_MAX) begin
            act = PIX_MAX[PIXEL_WIDTH-1:0];
        end else begin
            act = rnd[PIXEL_WIDTH-1:0];
        end
    end

    assign out_valid = (fifo_count != '0);
    assign push      = sum_valid;
    assign pop       = out_valid & out_ready;
    assign push_ok   = push & ((fifo_count < CNT_W'(DEPTH)) | pop);
    assign rd_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= act;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            out_pixel  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr <= rd_next;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            // Registered head: the new result becomes head when it lands on the read slot;
            // an emptied FIFO keeps showing the last popped value.
            if (push_ok && (rd_next == wr_ptr)) begin
                out_pixel <= act;
            end else if (pop && (fifo_count > CNT_W'(1))) begin
                out_pixel <= mem[rd_next];
            end
        end
    end

endmodule
